fpu_result_checker: RTL and testbench

//  Synthesizable response-side scoreboard for the pipelined FP test harness. The vector source

---
 rtl/fpu_result_checker.sv | 142 ++++++++++++++
 tb/tb_fpu_result_checker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_checker.sv
// rtl/fpu_result_checker.sv - in-order expected-vs-actual scoreboard for the FPU test harness
module fpu_result_checker #(
  parameter int DEPTH = 8,
  parameter int W     = 64,
  parameter int FW    = 5,
  parameter int CNTW  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            check_flags,
  input  logic            exp_valid,
  output logic            exp_ready,
  input  logic            exp_last,
  input  logic [W-1:0]    exp_op1,
  input  logic [W-1:0]    exp_op2,
  input  logic [W-1:0]    exp_result,
  input  logic [FW-1:0]   exp_flags,
  input  logic            res_valid,
  input  logic [W-1:0]    res_result,
  input  logic [FW-1:0]   res_flags,
  output logic            err_pulse,
  output logic [CNTW-1:0] vec_count,
  output logic [CNTW-1:0] err_count,
  output logic            first_err_valid,
  output logic [W-1:0]    first_err_op1,
  output logic [W-1:0]    first_err_op2,
  output logic [W-1:0]    first_err_got,
  output logic [W-1:0]    first_err_exp,
  output logic            proto_err,
  output logic            done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [AW:0]   wr_ptr, rd_ptr, occupancy;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          full, empty, active, push, pop, mismatch, proto_hit;

  logic          mem_last  [DEPTH];
  logic [W-1:0]  mem_op1   [DEPTH];
  logic [W-1:0]  mem_op2   [DEPTH];
  logic [W-1:0]  mem_res   [DEPTH];
  logic [FW-1:0] mem_flags [DEPTH];

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == FULL_CNT);
  assign empty     = (wr_ptr == rd_ptr);
  assign active    = (state == S_RUN) || (state == S_DRAIN);

  assign exp_ready = (state == S_RUN) && !full;
  assign done      = (state == S_DONE);

  // start flushes the queue on the same edge, so nothing is pushed or popped with it
  assign push      = exp_valid && exp_ready && !start;
  assign pop       = res_valid && active && !empty && !start;
  assign proto_hit = (res_valid && active && empty) || (exp_valid && (state == S_RUN) && full);

  assign mismatch  = (res_result != mem_res[rd_idx]) ||
                     (check_flags && (res_flags != mem_flags[rd_idx]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN:   if (push && exp_last) state_nxt = S_DRAIN;
        S_DRAIN: if (pop && mem_last[rd_idx]) state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_last[wr_idx]  <= exp_last;
      mem_op1[wr_idx]   <= exp_op1;
      mem_op2[wr_idx]   <= exp_op2;
      mem_res[wr_idx]   <= exp_result;
      mem_flags[wr_idx] <= exp_flags;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_pulse       <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_op1   <= '0;
      first_err_op2   <= '0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
      proto_err       <= 1'b0;
    end else if (start) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_pulse       <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_op1   <= '0;
      first_err_op2   <= '0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
      proto_err       <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        err_pulse <= mismatch;
        if (vec_count != '1) vec_count <= vec_count + 1'b1;
        if (mismatch && (err_count != '1)) err_count <= err_count + 1'b1;
        // only the first miscompare since start is captured
        if (mismatch && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_op1   <= mem_op1[rd_idx];
          first_err_op2   <= mem_op2[rd_idx];
          first_err_got   <= res_result;
          first_err_exp   <= mem_res[rd_idx];
        end
      end
      if (proto_hit) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_result_checker.sv
// tb/tb_fpu_result_checker.sv - randomized bench for fpu_result_checker with queue-based reference model
`timescale 1ns/1ps
module tb_fpu_result_checker;
  localparam int DEPTH = 8;
  localparam int W     = 64;
  localparam int FW    = 5;
  localparam int CNTW  = 32;
  localparam longint CNT_MAX = (64'd1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            check_flags = 1'b1;
  logic            exp_valid = 1'b0;
  logic            exp_ready;
  logic            exp_last = 1'b0;
  logic [W-1:0]    exp_op1 = '0, exp_op2 = '0, exp_result = '0;
  logic [FW-1:0]   exp_flags = '0;
  logic            res_valid = 1'b0;
  logic [W-1:0]    res_result = '0;
  logic [FW-1:0]   res_flags = '0;
  logic            err_pulse;
  logic [CNTW-1:0] vec_count, err_count;
  logic            first_err_valid;
  logic [W-1:0]    first_err_op1, first_err_op2, first_err_got, first_err_exp;
  logic            proto_err, done;

  fpu_result_checker #(.DEPTH(DEPTH), .W(W), .FW(FW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .start(start), .check_flags(check_flags),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_last(exp_last),
    .exp_op1(exp_op1), .exp_op2(exp_op2), .exp_result(exp_result), .exp_flags(exp_flags),
    .res_valid(res_valid), .res_result(res_result), .res_flags(res_flags),
    .err_pulse(err_pulse), .vec_count(vec_count), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_op1(first_err_op1),
    .first_err_op2(first_err_op2), .first_err_got(first_err_got),
    .first_err_exp(first_err_exp), .proto_err(proto_err), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: an ordered list of expected entries plus run phase
  typedef struct {
    logic          last;
    logic [W-1:0]  op1, op2, res;
    logic [FW-1:0] flags;
  } ent_t;
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mmode_t;

  ent_t   mq[$];
  ent_t   m_e;
  mmode_t m_mode = M_IDLE, m_mode0;
  longint m_vec = 0, m_err = 0;
  bit     m_pulse = 0, m_fev = 0, m_proto = 0, m_take = 0, m_mis = 0;
  logic [W-1:0] m_f1 = '0, m_f2 = '0, m_fg = '0, m_fe = '0;

  task automatic model_clear();
    mq.delete();
    m_vec = 0; m_err = 0; m_pulse = 0; m_fev = 0; m_proto = 0;
    m_f1 = '0; m_f2 = '0; m_fg = '0; m_fe = '0;
  endtask

  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      model_clear();
      m_mode = M_IDLE;
    end else if (start) begin
      model_clear();
      m_mode = M_RUN;
    end else begin
      m_mode0 = m_mode;
      m_take  = (m_mode == M_RUN) && (mq.size() < DEPTH);
      m_pulse = 0;
      if (res_valid && (m_mode0 == M_RUN || m_mode0 == M_DRAIN)) begin
        if (mq.size() == 0) m_proto = 1;
        else begin
          m_e = mq.pop_front();
          if (m_vec < CNT_MAX) m_vec++;
          m_mis = (res_result !== m_e.res) || (check_flags && (res_flags !== m_e.flags));
          if (m_mis) begin
            if (m_err < CNT_MAX) m_err++;
            m_pulse = 1;
            if (!m_fev) begin
              m_fev = 1; m_f1 = m_e.op1; m_f2 = m_e.op2; m_fg = res_result; m_fe = m_e.res;
            end
          end
          if (m_e.last) m_mode = M_DONE;
        end
      end
      if (exp_valid && m_mode0 == M_RUN) begin
        if (m_take) begin
          mq.push_back('{last: exp_last, op1: exp_op1, op2: exp_op2, res: exp_result, flags: exp_flags});
          if (exp_last) m_mode = M_DRAIN;
        end else m_proto = 1;
      end
    end
  end

  always begin
    @(negedge clk);
    chk("exp_ready", exp_ready, (m_mode == M_RUN) && (mq.size() < DEPTH));
    chk("done", done, m_mode == M_DONE);
    chk("err_pulse", err_pulse, m_pulse);
    chk("vec_count", vec_count, m_vec);
    chk("err_count", err_count, m_err);
    chk("proto_err", proto_err, m_proto);
    chk("first_err_valid", first_err_valid, m_fev);
    chk("first_err_op1", first_err_op1, m_f1);
    chk("first_err_op2", first_err_op2, m_f2);
    chk("first_err_got", first_err_got, m_fg);
    chk("first_err_exp", first_err_exp, m_fe);
  end

  // Stimulus: a fake FPU returns each accepted entry's result lat cycles later
  typedef struct {
    int            due;
    logic [W-1:0]  res;
    logic [FW-1:0] flags;
  } pend_t;
  pend_t pend[$];
  int    cyc = 0;
  int    lat = 2;
  bit    hold = 0;
  bit    force_res = 0;
  logic [W-1:0]  cur_rmask = '0;
  logic [FW-1:0] cur_fmask = '0;

  task automatic step(output bit acc);
    pend_t p;
    acc = exp_valid && exp_ready && reset;
    @(posedge clk);
    cyc++;
    if (acc) pend.push_back('{due: cyc - 1 + lat, res: exp_result ^ cur_rmask, flags: exp_flags ^ cur_fmask});
    #2;
    res_valid = 1'b0;
    if (force_res) begin
      res_valid  = 1'b1;
      res_result = {$urandom, $urandom};
      res_flags  = FW'($urandom);
    end else if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      res_valid  = 1'b1;
      res_result = p.res;
      res_flags  = p.flags;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic do_start();
    bit acc;
    start = 1'b1;
    step(acc);
    start = 1'b0;
  endtask

  task automatic push_entry(input logic [W-1:0] o1, input logic [W-1:0] o2, input logic [W-1:0] r,
                            input logic [FW-1:0] f, input bit last,
                            input logic [W-1:0] rm, input logic [FW-1:0] fm);
    bit acc;
    int n = 0;
    while (!exp_ready && n < 100) begin step(acc); n++; end
    exp_valid = 1'b1; exp_last = last;
    exp_op1 = o1; exp_op2 = o2; exp_result = r; exp_flags = f;
    cur_rmask = rm; cur_fmask = fm;
    step(acc);
    exp_valid = 1'b0; exp_last = 1'b0;
    if (!acc) chk("push_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((pend.size() > 0 || res_valid) && n < 300) begin idle(1); n++; end
    if (n >= 300) chk("drain_timeout", 64'd0, 64'd1);
    idle(3);
  endtask

  initial begin
    #1 reset = 1'b0;
    idle(2);
    chk("rst_exp_ready", exp_ready, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    idle(2);

    // basic matching run at latency 2
    do_start();
    lat = 2;
    for (int i = 0; i < 3; i++)
      push_entry(64'h10 + i, 64'h20 + i, 64'h3FF0000000000000, 5'b0, i == 2, '0, '0);
    drain();
    chk("t1_vec", vec_count, 3);
    chk("t1_err", err_count, 0);
    chk("t1_done", done, 1);

    // result miscompare and first-error capture
    do_start();
    push_entry(64'hA1, 64'hB1, 64'h3FF0000000000000, 5'b0, 0, '0, '0);
    push_entry(64'hA2, 64'hB2, 64'h4000000000000000, 5'b0, 0, 64'h1, '0);
    push_entry(64'hA3, 64'hB3, 64'h4008000000000000, 5'b0, 1, 64'h10, '0);
    drain();
    chk("t2_err", err_count, 2);
    chk("t2_got", first_err_got, 64'h4000000000000001);
    chk("t2_exp", first_err_exp, 64'h4000000000000000);
    chk("t2_op1", first_err_op1, 64'hA2);

    // flag-only mismatch with and without flag checking
    check_flags = 1'b1;
    do_start();
    push_entry(64'h1, 64'h2, 64'h3FF0000000000000, 5'b00000, 1, '0, 5'b00001);
    drain();
    chk("t3_flags_on", err_count, 1);
    check_flags = 1'b0;
    do_start();
    push_entry(64'h1, 64'h2, 64'h3FF0000000000000, 5'b00000, 1, '0, 5'b00001);
    drain();
    chk("t3_flags_off", err_count, 0);
    chk("t3_vec", vec_count, 1);
    check_flags = 1'b1;

    // fill to DEPTH with results held, then stream 20 at latency 7
    do_start();
    hold = 1; lat = 1;
    for (int i = 0; i < DEPTH; i++)
      push_entry({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, FW'($urandom), 0, '0, '0);
    chk("t4_full_ready", exp_ready, 0);
    hold = 0; lat = 7;
    for (int i = 0; i < 20; i++)
      push_entry({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, FW'($urandom), i == 19, '0, '0);
    drain();
    chk("t4_vec", vec_count, DEPTH + 20);
    chk("t4_proto", proto_err, 0);
    chk("t4_done", done, 1);

    // push while full is a protocol error
    do_start();
    hold = 1;
    for (int i = 0; i < DEPTH; i++)
      push_entry(64'h5, 64'h6, 64'h7, 5'b0, 0, '0, '0);
    exp_valid = 1'b1;
    idle(1);
    exp_valid = 1'b0;
    idle(1);
    chk("t4b_proto", proto_err, 1);
    hold = 0;
    drain();
    chk("t4b_vec", vec_count, DEPTH);

    // result with empty queue
    do_start();
    chk("t5_proto_clr", proto_err, 0);
    force_res = 1;
    idle(1);
    force_res = 0;
    idle(2);
    chk("t5_proto", proto_err, 1);
    chk("t5_vec", vec_count, 0);
    do_start();
    idle(1);
    chk("t5_restart_proto", proto_err, 0);

    // reset mid-run with entries queued
    do_start();
    hold = 1; lat = 1;
    for (int i = 0; i < 4; i++)
      push_entry(64'h9, 64'hA, 64'hB, 5'b0, 0, '0, '0);
    #1 reset = 1'b0;
    #1;
    chk("t6_ready", exp_ready, 0);
    chk("t6_vec", vec_count, 0);
    chk("t6_done", done, 0);
    chk("t6_proto", proto_err, 0);
    chk("t6_fev", first_err_valid, 0);
    pend.delete();
    hold = 0;
    idle(2);
    reset = 1'b1;
    idle(2);
    chk("t6_idle_ready", exp_ready, 0);

    // randomized runs
    for (int run = 0; run < 8; run++) begin
      int n;
      check_flags = 1'($urandom);
      lat = $urandom_range(1, 7);
      n = $urandom_range(5, 15);
      do_start();
      for (int i = 0; i < n; i++) begin
        logic [W-1:0]  rm;
        logic [FW-1:0] fm;
        rm = ($urandom_range(0, 3) == 0) ? (64'd1 << $urandom_range(0, 63)) : '0;
        fm = ($urandom_range(0, 3) == 0) ? FW'(1 << $urandom_range(0, FW - 1)) : '0;
        idle($urandom_range(0, 2));
        push_entry({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   FW'($urandom), i == n - 1, rm, fm);
      end
      drain();
      chk("rand_done", done, 1);
      chk("rand_vec", vec_count, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
